mul_operand_sequencer: RTL and testbench
========================================

Name: mul_operand_sequencer

Overview:
- Upstream issue/capture stage for the 8-bit signed combinational multiplier.
- Accepts operand pairs over a valid/ready handshake and holds them stable on the multiplier inputs for a programmable settle window.
- Captures the multiplier's 8-bit product into a result register and presents it downstream over a second valid/ready handshake, with status flags and an operation counter.

Parameters:
SETTLE_CYCLES, 2, clock cycles the operands are held before the product is sampled; legal range 1..15
COUNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  sequencer can accept an operand pair this cycle
in_a  input  8  signed operand x
in_b  input  8  signed operand y
mul_x  output  8  registered operand to the multiplier x input
mul_y  output  8  registered operand to the multiplier y input
mul_out  input  8  combinational product from the multiplier
res_valid  output  1  result register holds an unconsumed product
res_ready  input  1  downstream accepts the result this cycle
res_data  output  8  captured product
res_zero  output  1  res_data == 0
res_neg  output  1  res_data[7]
busy  output  1  state != IDLE
op_count  output  COUNT_W  number of results consumed downstream

Behaviour:
- Reset (async, immediate, regardless of state): state=IDLE; mul_x, mul_y, res_data = 0; res_valid = 0; op_count = 0; settle counter = 0. Consequently res_zero=1, res_neg=0, busy=0, in_ready=1.
- States: IDLE, SETTLE, HOLD.
- Operand transfer: occurs on a rising edge where in_valid && in_ready.
- Result transfer: occurs on a rising edge where res_valid && res_ready.
- in_ready = (state==IDLE) || (state==HOLD && res_ready). This is a combinational path from res_ready and is intended.
- IDLE:
  - On operand transfer: mul_x<=in_a, mul_y<=in_b, cnt<=SETTLE_CYCLES-1, go to SETTLE.
  - Otherwise remain in IDLE.
- SETTLE:
  - mul_x and mul_y are held constant; in_valid is ignored.
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: res_data<=mul_out, res_valid<=1, go to HOLD.
- HOLD:
  - res_data is held constant while res_valid=1 and res_ready=0.
  - On result transfer without operand transfer: res_valid<=0, op_count<=op_count+1, go to IDLE.
  - On simultaneous result and operand transfer (back-to-back): op_count increments, res_valid<=0, new operands are latched, cnt<=SETTLE_CYCLES-1, go to SETTLE. No idle bubble.
- Latency: res_valid rises SETTLE_CYCLES clock edges after the operand-transfer edge (SETTLE_CYCLES=2 gives 2 cycles).
- Throughput: one result per SETTLE_CYCLES+1 cycles with res_ready held high.
- res_data is not cleared when the result is consumed; it holds the last product until the next capture.
- res_zero and res_neg are combinational from res_data.
- op_count wraps modulo 2^COUNT_W with no saturation or flag.
- mul_out is sampled only on the capture edge; glitches on it at any other time have no effect.
- Reset asserted mid-SETTLE or mid-HOLD discards the in-flight operation; op_count does not increment.
- in_a and in_b are don't-care when in_valid=0. The input payload is not required to be held after transfer.

Test Plan:
- Reset release, idle -> in_ready=1, res_valid=0, busy=0, res_zero=1, op_count=0.
- Operands in_a=8'h03, in_b=8'h05, SETTLE_CYCLES=2, res_ready=1, real multiplier attached -> res_valid high exactly 2 edges after transfer, res_data=8'h0F, res_neg=0; op_count=1 after consumption.
- Operands 8'hFD × 8'h05 with res_ready=0 for 5 cycles -> res_data=8'hF1, res_neg=1, held stable and res_valid held for all 5 cycles, in_ready=0 throughout; op_count increments once when res_ready rises.
- Back-to-back: pairs (2,3), (4,4), (0,8'hFB) with in_valid and res_ready held high -> results 8'h06, 8'h10, 8'h00 (res_zero=1), one per 3 cycles with no bubble; op_count=3.
- Reset pulsed during SETTLE after accepting (7,7) -> outputs return to reset values immediately; no result is presented; op_count stays 0.
- COUNT_W=4, 17 consumed operations -> op_count=1 (wrap).

Source files
------------

// File: rtl/mul_operand_sequencer.sv
// Issue/capture stage for the 8-bit signed combinational multiplier.
// Holds operands for a settle window, then captures the product and hands it downstream.
module mul_operand_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned COUNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_a,
  input  logic [7:0]         in_b,
  output logic [7:0]         mul_x,
  output logic [7:0]         mul_y,
  input  logic [7:0]         mul_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [7:0]         res_data,
  output logic               res_zero,
  output logic               res_neg,
  output logic               busy,
  output logic [COUNT_W-1:0] op_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       in_xfer;
  logic       res_xfer;

  // in_ready depends combinationally on res_ready so HOLD can refill without a bubble.
  assign in_ready = (state == IDLE) || ((state == HOLD) && res_ready);
  assign in_xfer  = in_valid && in_ready;
  assign res_xfer = res_valid && res_ready;
  assign res_zero = (res_data == 8'h00);
  assign res_neg  = res_data[7];
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mul_x     <= '0;
      mul_y     <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_xfer) begin
            mul_x <= in_a;
            mul_y <= in_b;
            cnt   <= CNT_INIT;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            res_data  <= mul_out;
            res_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (res_xfer) begin
            res_valid <= 1'b0;
            op_count  <= op_count + COUNT_W'(1);
            if (in_xfer) begin
              mul_x <= in_a;
              mul_y <= in_b;
              cnt   <= CNT_INIT;
              state <= SETTLE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Directed bench for mul_operand_sequencer with a behavioural signed multiplier attached.
module tb_mul_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [7:0] mul_x;
  logic [7:0] mul_y;
  logic [7:0] mul_out;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_zero;
  logic       res_neg;
  logic       busy;
  logic [3:0] op_count;

  logic signed [15:0] prod;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign prod    = $signed(mul_x) * $signed(mul_y);
  assign mul_out = prod[7:0];

  mul_operand_sequencer #(
    .SETTLE_CYCLES(2),
    .COUNT_W      (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .mul_x    (mul_x),
    .mul_y    (mul_y),
    .mul_out  (mul_out),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_zero (res_zero),
    .res_neg  (res_neg),
    .busy     (busy),
    .op_count (op_count)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".res_zero"}, 32'(res_zero), 32'd1);
    chk({tag, ".res_neg"}, 32'(res_neg), 32'd0);
    chk({tag, ".res_data"}, 32'(res_data), 32'h00);
    chk({tag, ".mul_x"}, 32'(mul_x), 32'h00);
    chk({tag, ".op_count"}, 32'(op_count), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    #12 rst = 1'b0;
    tick();

    // Reset state
    chk_reset_outputs("rst");

    // 3 x 5, res_ready high: result two edges after transfer
    in_valid = 1'b1; in_a = 8'h03; in_b = 8'h05; res_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_a = 8'hAA; in_b = 8'h55;
    chk("t2.e0.busy", 32'(busy), 32'd1);
    chk("t2.e0.in_ready", 32'(in_ready), 32'd0);
    chk("t2.e0.mul_x", 32'(mul_x), 32'h03);
    chk("t2.e0.mul_y", 32'(mul_y), 32'h05);
    chk("t2.e0.res_valid", 32'(res_valid), 32'd0);
    tick();
    chk("t2.e1.res_valid", 32'(res_valid), 32'd0);
    chk("t2.e1.mul_x", 32'(mul_x), 32'h03);
    tick();
    chk("t2.e2.res_valid", 32'(res_valid), 32'd1);
    chk("t2.e2.res_data", 32'(res_data), 32'h0F);
    chk("t2.e2.res_neg", 32'(res_neg), 32'd0);
    chk("t2.e2.res_zero", 32'(res_zero), 32'd0);
    tick();
    chk("t2.e3.res_valid", 32'(res_valid), 32'd0);
    chk("t2.e3.op_count", 32'(op_count), 32'd1);
    chk("t2.e3.busy", 32'(busy), 32'd0);
    chk("t2.e3.res_data_kept", 32'(res_data), 32'h0F);

    // -3 x 5 with downstream stalled for five cycles
    res_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'hFD; in_b = 8'h05;
    tick();
    in_valid = 1'b0;
    chk("t3.e0.in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("t3.e1.in_ready", 32'(in_ready), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22;
      chk("t3.stall.res_valid", 32'(res_valid), 32'd1);
      chk("t3.stall.res_data", 32'(res_data), 32'hF1);
      chk("t3.stall.res_neg", 32'(res_neg), 32'd1);
      chk("t3.stall.in_ready", 32'(in_ready), 32'd0);
      chk("t3.stall.op_count", 32'(op_count), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    #1;
    chk("t3.release.in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("t3.done.res_valid", 32'(res_valid), 32'd0);
    chk("t3.done.op_count", 32'(op_count), 32'd2);
    chk("t3.done.busy", 32'(busy), 32'd0);

    // Back-to-back: (2,3), (4,4), (0,-5) with in_valid and res_ready high
    in_valid = 1'b1; in_a = 8'h02; in_b = 8'h03;
    tick();
    in_a = 8'h04; in_b = 8'h04;
    tick();
    chk("t4.r0.pre", 32'(res_valid), 32'd0);
    tick();
    chk("t4.r0.valid", 32'(res_valid), 32'd1);
    chk("t4.r0.data", 32'(res_data), 32'h06);
    chk("t4.r0.in_ready", 32'(in_ready), 32'd1);
    tick();
    in_a = 8'h00; in_b = 8'hFB;
    chk("t4.b2b1.busy", 32'(busy), 32'd1);
    chk("t4.b2b1.mul_x", 32'(mul_x), 32'h04);
    chk("t4.b2b1.op_count", 32'(op_count), 32'd3);
    chk("t4.b2b1.res_valid", 32'(res_valid), 32'd0);
    tick();
    tick();
    chk("t4.r1.valid", 32'(res_valid), 32'd1);
    chk("t4.r1.data", 32'(res_data), 32'h10);
    tick();
    in_valid = 1'b0;
    chk("t4.b2b2.mul_y", 32'(mul_y), 32'hFB);
    chk("t4.b2b2.op_count", 32'(op_count), 32'd4);
    tick();
    tick();
    chk("t4.r2.valid", 32'(res_valid), 32'd1);
    chk("t4.r2.data", 32'(res_data), 32'h00);
    chk("t4.r2.zero", 32'(res_zero), 32'd1);
    tick();
    chk("t4.end.op_count", 32'(op_count), 32'd5);
    chk("t4.end.busy", 32'(busy), 32'd0);

    // Reset pulsed mid-SETTLE after accepting (7,7)
    in_valid = 1'b1; in_a = 8'h07; in_b = 8'h07;
    tick();
    in_valid = 1'b0;
    chk("t5.accepted.busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("t5.async");
    tick();
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5.after.res_valid", 32'(res_valid), 32'd0);
      chk("t5.after.busy", 32'(busy), 32'd0);
      chk("t5.after.op_count", 32'(op_count), 32'd0);
    end

    // 17 consumed operations on a 4-bit counter wrap to 1
    res_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_a = 8'h01; in_b = 8'h01;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      if (i == 15) chk("t6.wrap16", 32'(op_count), 32'd0);
    end
    chk("t6.wrap17", 32'(op_count), 32'd1);
    chk("t6.res_data", 32'(res_data), 32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
